// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream injection port between NUM_SRC sources.
// Define AXIS_ARB_PKT_LOCK_EN to hold the grant for whole packets (release on tlast).
module axis_rr_arbiter #(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_SRC    = 4,
  localparam int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grantId_q, grantId_d;
  logic [IDX_W-1:0]   lastId_q, lastId_d;

  logic [NUM_SRC-1:0] reqMask;
  logic [IDX_W-1:0]   scanBase;
  logic [IDX_W-1:0]   cand;
  logic               pickValid;
  logic [IDX_W-1:0]   pickId;
  logic               selValid;
  logic               beatXfer;
  logic               releaseBeat;

  assign grant_valid   = rst & (state_q == BUSY);
  assign grant_id      = grantId_q;
  assign m_axis_tvalid = grant_valid & selValid;
  assign beatXfer      = m_axis_tvalid & m_axis_tready;

`ifdef AXIS_ARB_PKT_LOCK_EN
  assign releaseBeat = beatXfer & m_axis_tlast;
`else
  assign releaseBeat = beatXfer;
`endif

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    selValid      = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grantId_q == IDX_W'(i)) begin
        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast     = s_axis_tlast[i];
        selValid         = s_axis_tvalid[i];
        s_axis_tready[i] = grant_valid & m_axis_tready;
      end
    end
  end

  // The owner still shows tvalid on its releasing beat; it only counts as a
  // requester again when that beat is not the end of its packet.
  always_comb begin
    reqMask = s_axis_tvalid;
    if (state_q == BUSY) begin
      reqMask[grantId_q] = s_axis_tvalid[grantId_q] & ~s_axis_tlast[grantId_q];
    end
  end

  assign scanBase = (state_q == BUSY) ? grantId_q : lastId_q;

  always_comb begin
    pickValid = 1'b0;
    pickId    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(scanBase) + k) % NUM_SRC);
      if (!pickValid && reqMask[cand]) begin
        pickValid = 1'b1;
        pickId    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    lastId_d  = lastId_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d   = BUSY;
          grantId_d = pickId;
        end
      end
      BUSY: begin
        if (releaseBeat) begin
          lastId_d = grantId_q;
          if (pickValid) begin
            grantId_d = pickId;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // lastId resets to the highest index so source 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      lastId_q  <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      lastId_q  <= lastId_d;
    end
  end

endmodule
